// File: rtl/serial_sub_nbit.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow, with valid/ready on both sides.
module serial_sub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic             amsb;
    logic             bmsb;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;

    // The single full-subtractor cell working on the current LSBs.
    assign d_bit     = sa[0] ^ sb[0] ^ br;
    assign br_next   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign diff_next = {d_bit, diff[WIDTH-1:1]};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            br        <= 1'b0;
            amsb      <= 1'b0;
            bmsb      <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bo        <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        amsb  <= a[WIDTH-1];
                        bmsb  <= b[WIDTH-1];
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= br_next;
                    diff <= diff_next;
                    cnt  <= cnt + 1'b1;
                    // Flags are taken from the final bit pattern as it enters the register.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bo        <= br_next;
                        zero      <= (diff_next == '0);
                        ovf       <= (amsb != bmsb) && (diff_next[WIDTH-1] != amsb);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Self-checking bench for serial_sub_nbit at WIDTH 8, 16 and 2, using an
// arithmetic reference model of a - b - bin with signed-range overflow.
module tb_serial_sub_nbit;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic iv8, ir8, ov8, or8, bin8, bo8, z8, of8, bs8;
    logic [7:0] a8, b8, d8;
    logic iv16, ir16, ov16, or16, bin16, bo16, z16, of16, bs16;
    logic [15:0] a16, b16, d16;
    logic iv2, ir2, ov2, or2, bin2, bo2, z2, of2, bs2;
    logic [1:0] a2, b2, d2;

    serial_sub_nbit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bo(bo8), .zero(z8), .ovf(of8), .busy(bs8));
    serial_sub_nbit #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
        .out_valid(ov16), .out_ready(or16), .diff(d16), .bo(bo16), .zero(z16), .ovf(of16), .busy(bs16));
    serial_sub_nbit #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .bin(bin2),
        .out_valid(ov2), .out_ready(or2), .diff(d2), .bo(bo2), .zero(z2), .ovf(of2), .busy(bs2));

    task automatic setIn(input int w, input logic v, input logic [63:0] av, input logic [63:0] bv,
                         input logic bi);
        case (w)
            8:       begin iv8  = v; a8  = av[7:0];  b8  = bv[7:0];  bin8  = bi; end
            16:      begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; bin16 = bi; end
            default: begin iv2  = v; a2  = av[1:0];  b2  = bv[1:0];  bin2  = bi; end
        endcase
    endtask

    task automatic setRdy(input int w, input logic r);
        case (w)
            8:       or8  = r;
            16:      or16 = r;
            default: or2  = r;
        endcase
    endtask

    task automatic getOut(input int w, output logic [63:0] d, output logic ov, output logic ir,
                          output logic bs, output logic bo, output logic z, output logic of);
        case (w)
            8:       begin d = 64'(d8);  ov = ov8;  ir = ir8;  bs = bs8;  bo = bo8;  z = z8;  of = of8;  end
            16:      begin d = 64'(d16); ov = ov16; ir = ir16; bs = bs16; bo = bo16; z = z16; of = of16; end
            default: begin d = 64'(d2);  ov = ov2;  ir = ir2;  bs = bs2;  bo = bo2;  z = z2;  of = of2;  end
        endcase
    endtask

    // Reference: integer subtraction, unsigned borrow and signed-range overflow.
    task automatic refModel(input int w, input logic [63:0] av, input logic [63:0] bv, input logic bi,
                            output logic [63:0] d, output logic bo, output logic z, output logic of);
        logic [63:0] mask;
        longint ua, ub, r, half, full, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        ua   = longint'(av & mask);
        ub   = longint'(bv & mask);
        r    = ua - ub - longint'(bi);
        bo   = (r < 0);
        d    = 64'(r) & mask;
        z    = (d == 64'd0);
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        sr   = sa - sb - longint'(bi);
        of   = (sr < -half) || (sr > half - 1);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge where out_valid is first seen.
    task automatic applyStimulus(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic bi, input logic keep_valid, output int lat,
                                 output int unsigned acc);
        logic [63:0] d;
        logic ov, ir, bs, bo, z, of;
        setIn(w, 1'b1, av, bv, bi);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        setIn(w, keep_valid, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        lat = 0;
        getOut(w, d, ov, ir, bs, bo, z, of);
        while (!ov && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            getOut(w, d, ov, ir, bs, bo, z, of);
        end
    endtask

    task automatic releaseOut(input int w, input string tag);
        logic [63:0] d;
        logic ov, ir, bs, bo, z, of;
        setRdy(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setRdy(w, 1'b0);
        getOut(w, d, ov, ir, bs, bo, z, of);
        checkOutput({tag, "_ov_drop"}, 64'(ov), 64'd0);
        checkOutput({tag, "_ir_back"}, 64'(ir), 64'd1);
    endtask

    task automatic directedOp(input int w, input logic [63:0] av, input logic [63:0] bv,
                              input logic bi, input logic [63:0] ed, input logic ebo,
                              input logic ez, input logic eof, input string tag);
        logic [63:0] d;
        logic ov, ir, bs, bo, z, of;
        int lat;
        int unsigned acc;
        applyStimulus(w, av, bv, bi, 1'b0, lat, acc);
        getOut(w, d, ov, ir, bs, bo, z, of);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(w));
        checkOutput({tag, "_diff"}, d, ed);
        checkOutput({tag, "_bo"}, 64'(bo), 64'(ebo));
        checkOutput({tag, "_zero"}, 64'(z), 64'(ez));
        checkOutput({tag, "_ovf"}, 64'(of), 64'(eof));
        releaseOut(w, tag);
    endtask

    task automatic randomRun(input int w, input int n);
        logic [63:0] d, ed, mask, av, bv;
        logic ov, ir, bs, bo, z, of, bi, ebo, ez, eof;
        int lat;
        int unsigned acc, prev;
        mask = (64'd1 << w) - 64'd1;
        prev = 0;
        setRdy(w, 1'b1);
        for (int i = 0; i < n; i++) begin
            av = {$urandom, $urandom} & mask;
            bv = {$urandom, $urandom} & mask;
            bi = 1'($urandom);
            applyStimulus(w, av, bv, bi, 1'b1, lat, acc);
            getOut(w, d, ov, ir, bs, bo, z, of);
            refModel(w, av, bv, bi, ed, ebo, ez, eof);
            checkOutput("rnd_lat", 64'(lat), 64'(w));
            checkOutput("rnd_diff", d, ed);
            checkOutput("rnd_bo", 64'(bo), 64'(ebo));
            checkOutput("rnd_zero", 64'(z), 64'(ez));
            checkOutput("rnd_ovf", 64'(of), 64'(eof));
            if (i > 0) checkOutput("rnd_period", 64'(acc - prev), 64'(w + 2));
            prev = acc;
            @(posedge clk);
            @(negedge clk);
        end
        setIn(w, 1'b0, 64'd0, 64'd0, 1'b0);
        setRdy(w, 1'b0);
    endtask

    initial begin
        logic [63:0] d;
        logic ov, ir, bs, bo, z, of, seen_ov;
        int lat;
        int unsigned acc;

        rst_n = 1'b0;
        setIn(8, 1'b0, 64'd0, 64'd0, 1'b0);
        setIn(16, 1'b0, 64'd0, 64'd0, 1'b0);
        setIn(2, 1'b0, 64'd0, 64'd0, 1'b0);
        setRdy(8, 1'b0);
        setRdy(16, 1'b0);
        setRdy(2, 1'b0);
        #2;
        getOut(8, d, ov, ir, bs, bo, z, of);
        checkOutput("rst_ov", 64'(ov), 64'd0);
        checkOutput("rst_ir", 64'(ir), 64'd1);
        checkOutput("rst_busy", 64'(bs), 64'd0);
        checkOutput("rst_diff", d, 64'd0);
        checkOutput("rst_flags", {61'd0, bo, z, of}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directedOp(8, 64'h0F, 64'h05, 1'b0, 64'h0A, 1'b0, 1'b0, 1'b0, "t1");
        directedOp(8, 64'h05, 64'h0F, 1'b0, 64'hF6, 1'b1, 1'b0, 1'b0, "t2a");
        directedOp(8, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b0, 1'b1, "t2b");
        directedOp(8, 64'h3C, 64'h3C, 1'b1, 64'hFF, 1'b1, 1'b0, 1'b0, "t3a");
        directedOp(8, 64'h3C, 64'h3B, 1'b1, 64'h00, 1'b0, 1'b1, 1'b0, "t3b");

        // Backpressure with an ignored in_valid pulse while DONE.
        applyStimulus(8, 64'h9A, 64'h27, 1'b0, 1'b0, lat, acc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) setIn(8, 1'b1, 64'h11, 64'h22, 1'b1);
            if (i == 2) setIn(8, 1'b0, 64'h00, 64'h00, 1'b0);
            getOut(8, d, ov, ir, bs, bo, z, of);
            checkOutput("t4_ov_hold", 64'(ov), 64'd1);
            checkOutput("t4_ir_low", 64'(ir), 64'd0);
            checkOutput("t4_diff_hold", d, 64'h73);
        end
        releaseOut(8, "t4");
        repeat (3) @(negedge clk);
        getOut(8, d, ov, ir, bs, bo, z, of);
        checkOutput("t4_not_taken", 64'(bs), 64'd0);
        checkOutput("t4_diff_kept", d, 64'h73);

        // Reset in the middle of SHIFT discards the operation.
        setIn(8, 1'b1, 64'h55, 64'h0A, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setIn(8, 1'b0, 64'h00, 64'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        getOut(8, d, ov, ir, bs, bo, z, of);
        checkOutput("t5_busy", 64'(bs), 64'd0);
        checkOutput("t5_ov", 64'(ov), 64'd0);
        checkOutput("t5_ir", 64'(ir), 64'd1);
        checkOutput("t5_diff", d, 64'd0);
        checkOutput("t5_bo", 64'(bo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            getOut(8, d, ov, ir, bs, bo, z, of);
            seen_ov = seen_ov | ov | bs;
        end
        checkOutput("t5_no_output", 64'(seen_ov), 64'd0);
        directedOp(8, 64'hFF, 64'h01, 1'b0, 64'hFE, 1'b0, 1'b0, 1'b0, "t5b");

        randomRun(16, 1000);
        randomRun(2, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub_nbit.md
Name: serial_sub_nbit

Overview:
Parametrised bit-serial N-bit subtractor with borrow-in. It computes diff = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. Operands arrive on a valid/ready input handshake and results leave on a valid/ready output handshake. It is the multi-bit, sequential successor to the team's single-bit half/full subtractor cells, sized for area-constrained datapaths.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a, b, bin valid.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow-in, for chaining.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
bo  output  1  borrow-out from the MSB.
zero  output  1  diff == 0.
ovf  output  1  two's-complement signed overflow.
busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Shift registers, borrow FF, bit counter, diff, bo, zero, ovf and out_valid all clear to 0. busy=0 and in_ready=1 while in reset. Reset takes effect immediately, including mid-SHIFT; any partial result is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0, latch a→sa, b→sb, bin→borrow FF, a[WIDTH-1]→amsb, b[WIDTH-1]→bmsb, cnt=0, and go to SHIFT.
  - SHIFT: in_ready=0, busy=1. At each edge:
    - d = sa[0]^sb[0]^br
    - br' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
    - diff register shifts right with d entering at the MSB; sa and sb shift right; cnt++.
    - On the edge processing cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1. diff, bo=br, zero and ovf are stable and registered. On out_valid&&out_ready go to IDLE and deassert out_valid on that edge.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge E0.
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH shifts, ≥1 DONE, 1 IDLE).
- Output timing:
  - zero and ovf are computed combinationally from final values but registered on the SHIFT→DONE edge. They are valid only when out_valid=1.
  - diff, bo, zero and ovf hold their last values in IDLE until the next result overwrites them.
- ovf = (amsb != bmsb) && (diff[WIDTH-1] != amsb).
- Width rules: unsigned interpretation gives bo=1 iff a < b + bin. Result wraps modulo 2^WIDTH.
- Boundary conditions:
  - in_valid during SHIFT or DONE: ignored (in_ready=0), not queued.
  - out_ready while out_valid=0: ignored.
  - out_ready held high: DONE lasts exactly 1 cycle.
  - Input ports a, b and bin may change freely after E0 without affecting the result.
  - Counter width is $clog2(WIDTH); no wrap occurs before the DONE transition.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x05, bin=0 → diff=0x0A, bo=0, zero=0, ovf=0; out_valid rises exactly 8 cycles after accept.
2. a=0x05, b=0x0F, bin=0 → diff=0xF6, bo=1, ovf=0. Then a=0x80, b=0x01 → diff=0x7F, bo=0, ovf=1.
3. Borrow-in:
   - a=0x3C, b=0x3C, bin=1 → diff=0xFF, bo=1, zero=0.
   - a=0x3C, b=0x3B, bin=1 → diff=0x00, bo=0, zero=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulse in_valid with new operands meanwhile → outputs held, in_ready=0, new operands not taken. out_ready=1 → IDLE next edge, in_ready=1.
5. Reset mid-op: assert rst_n=0 at the 4th SHIFT cycle → outputs 0 and busy=0 immediately, with no out_valid. After release, a=0xFF, b=0x01 → diff=0xFE, bo=0.
6. WIDTH=16 and WIDTH=2: 1000 random a, b, bin compared to a reference (a-b-bin) model for diff, bo and ovf; back-to-back operation with out_ready=1 gives an accept every WIDTH+2 cycles.
